reg_file_sequencer: RTL and testbench
=====================================

Name: reg_file_sequencer

Overview:
Multi-cycle control unit for the 4-bit CPU.
- Fetches 12-bit instructions by PC, decodes them and drives the select/write ports of the 4x4 register file (2 read ports, 1 write port).
- Computes results with an internal 4-bit ALU.
- Sits between instruction ROM and reg_file. It is the only writer of the register file.

Parameters:
PC_W, 4, program counter width (16-instruction space)
DATA_W, 4, register/data width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
run  in  1  start/continue execution; sampled in IDLE and at end of WB
instr  in  12  instruction word from combinational ROM at address pc
pc  out  PC_W  instruction address
sel_a  out  2  register file read port A select
sel_b  out  2  register file read port B select
sel_w  out  2  register file write select
write_en  out  1  register file write enable
data_in  out  DATA_W  register file write data
out_a  in  DATA_W  register file read data A (combinational)
out_b  in  DATA_W  register file read data B (combinational)
zero  out  1  Z flag
halted  out  1  high in HALT state
illegal  out  1  illegal-opcode indicator (see Optional Feature)

Behaviour:
- Instruction fields: opcode = instr[11:8], rd = [7:6], rs = [5:4], imm = [3:0].
- Opcodes:
  - 0 NOP
  - 1 LDI: rd <= imm
  - 2 MOV: rd <= rs
  - 3 ADD: rd <= rd + rs
  - 4 SUB: rd <= rd - rs
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 JMP: pc <= imm
  - 9 JZ: pc <= imm if zero, else pc+1
  - A HALT
  - B-F undefined
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. Every instruction takes 4 cycles (FETCH..WB).
  - IDLE: wait for run=1, then go to FETCH.
  - FETCH: latch instr into IR. Go to DECODE.
  - DECODE: sel_a=rd, sel_b=rs. Go to EXEC.
  - EXEC: sel_a and sel_b are held. Latch ALU result from out_a/out_b/imm into result register. Update zero for opcodes 3-7 only. Go to WB, or to HALT if opcode=A.
  - WB:
    - For opcodes 1-7: write_en=1, sel_w=rd, data_in=result.
    - All other opcodes: write_en=0.
    - pc updated per opcode.
    - Next state is FETCH if run=1, else IDLE.
  - HALT: halted=1. pc frozen. Left only by rst.
- write_en is high only during WB, for exactly one cycle per writing instruction. The reg_file write lands on the rising edge that ends WB.
- sel_w and data_in are held from WB until the next WB.
- Arithmetic is modulo 2^DATA_W. Carry/borrow is discarded. zero = (result == 0).
- pc wraps from 15 to 0 on increment.
- rd == rs is legal. Example: ADD r1,r1 doubles r1.
- Reset values: state IDLE, pc = RESET_PC, IR = 0, sel_a = sel_b = sel_w = 0, write_en = 0, data_in = 0, zero = 0, halted = 0, illegal = 0.
- rst in any state, including mid-instruction, aborts immediately. No write occurs in the cycle rst is high; write_en is forced to 0.
- run deasserted mid-instruction: the instruction completes, then the FSM enters IDLE. pc already points to the next instruction.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: opcodes B-F go EXEC -> HALT with illegal=1 and halted=1. illegal is held until rst. pc is left at the offending address.
- Undefined: opcodes B-F execute as NOP (no write, pc+1). illegal is tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP .. OP_HALT)
  - FSM state encoding
  - instruction field bit positions
  - DATA_W/PC_W defaults
- One sub-module, seq_alu: a combinational 4-bit ALU with inputs op, a, b, imm and outputs result, zero. It is reused later by the datapath.

Test Plan:
- Program "LDI r0,5; LDI r1,3; ADD r0,r1; HALT" with run=1 -> write_en pulses in cycles 4, 8, 12 with data_in 5, 3, 8. Final r0=8, zero=0, halted=1 at cycle 16, pc=3.
- Program "LDI r2,7; SUB r2,r2; JZ 6", with r3 written at address 6 -> zero=1 after SUB, pc jumps to 6. Repeat with a nonzero result -> pc=3.
- Overflow and wrap:
  - "LDI r0,F; LDI r1,1; ADD r0,r1" -> data_in=0, zero=1.
  - Separately, run through pc=15 with NOPs -> pc wraps to 0.
- Assert rst during EXEC of an ADD -> write_en never asserts. Next cycle: pc=0, state IDLE, all outputs at reset values.
- Drop run during DECODE of "LDI r1,9" -> write of 9 to r1 still occurs. FSM enters IDLE with pc=1. Reassert run -> resumes at pc=1.
- Opcode 0xC:
  - With ILLEGAL_TRAP_EN: illegal=1, halted=1, no write.
  - Without: behaves as NOP, pc advances by 1.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, instruction fields and FSM encoding for the
//               4-bit CPU control unit and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int PC_W_DEF   = 4;
    localparam int INSTR_W    = 12;

    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 6;
    localparam int RS_MSB  = 5;
    localparam int RS_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    function automatic logic writes_reg(input logic [3:0] op);
        return (op >= OP_LDI) && (op <= OP_XOR);
    endfunction

    function automatic logic sets_flag(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic is_undefined(input logic [3:0] op);
        return op > OP_HALT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Combinational ALU: LDI/MOV pass-through plus ADD/SUB/AND/OR/XOR,
//               all modulo 2^DATA_W, with zero detect on the result.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        imm,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_LDI:  result = DATA_W'(imm);
            OP_MOV:  result = b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/reg_file_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/WB control unit driving a 4x4
//               register file. Optional macro ILLEGAL_TRAP_EN traps opcodes B-F.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [INSTR_W-1:0]  instr,
    output logic [PC_W-1:0]     pc,
    output logic [1:0]          sel_a,
    output logic [1:0]          sel_b,
    output logic [1:0]          sel_w,
    output logic                write_en,
    output logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W-1:0]   out_a,
    input  logic [DATA_W-1:0]   out_b,
    output logic                zero,
    output logic                halted,
    output logic                illegal
);

    state_t               state;
    state_t               next_state;
    logic [INSTR_W-1:0]   ir;
    logic                 wr_pend;
    logic [PC_W-1:0]      pc_next;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_zero;

    logic [3:0] opcode;
    logic [1:0] rd;
    logic [3:0] imm;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (opcode),
        .a      (out_a),
        .b      (out_b),
        .imm    (imm),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (run) next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC: begin
                if (opcode == OP_HALT)
                    next_state = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
                else if (is_undefined(opcode))
                    next_state = ST_HALT;
`endif
                else
                    next_state = ST_WB;
            end
            ST_WB:     next_state = run ? ST_FETCH : ST_IDLE;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_next = pc + PC_W'(1);
        case (opcode)
            OP_JMP:  pc_next = PC_W'(imm);
            OP_JZ:   if (zero) pc_next = PC_W'(imm);
            default: ;
        endcase
    end

    // Read selects are loaded straight from the ROM word so they are valid
    // throughout DECODE and EXEC; the write port is loaded as EXEC ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= PC_W'(RESET_PC);
            ir      <= '0;
            sel_a   <= '0;
            sel_b   <= '0;
            sel_w   <= '0;
            data_in <= '0;
            wr_pend <= 1'b0;
            zero    <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            case (state)
                ST_FETCH: begin
                    ir    <= instr;
                    sel_a <= instr[RD_MSB:RD_LSB];
                    sel_b <= instr[RS_MSB:RS_LSB];
                end
                ST_EXEC: begin
                    if (sets_flag(opcode))
                        zero <= alu_zero;
                    if (writes_reg(opcode)) begin
                        wr_pend <= 1'b1;
                        sel_w   <= rd;
                        data_in <= alu_result;
                    end
                end
                ST_WB:   pc <= pc_next;
                default: ;
            endcase
        end
    end

    // Reset must suppress a write even when it lands in the WB cycle.
    assign write_en = wr_pend & ~rst;
    assign halted   = (state == ST_HALT);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (state == ST_EXEC && is_undefined(opcode))
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sequencer
// Description : Directed self-checking bench with ROM and register-file models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        clr;
    logic [11:0] instr;
    logic [3:0]  pc;
    logic [1:0]  sel_a, sel_b, sel_w;
    logic        write_en;
    logic [3:0]  data_in;
    logic [3:0]  out_a, out_b;
    logic        zero, halted, illegal;

    logic [11:0] rom  [16];
    logic [3:0]  regs [4];
    int          wr_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .instr    (instr),
        .pc       (pc),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .sel_w    (sel_w),
        .write_en (write_en),
        .data_in  (data_in),
        .out_a    (out_a),
        .out_b    (out_b),
        .zero     (zero),
        .halted   (halted),
        .illegal  (illegal)
    );

    assign instr = rom[pc];
    assign out_a = regs[sel_a];
    assign out_b = regs[sel_b];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) regs[i] <= 4'h0;
            wr_count <= 0;
        end else if (write_en) begin
            regs[sel_w] <= data_in;
            wr_count    <= wr_count + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    endtask

    // Holds reset for two edges; the next rising edge after return is "edge 1".
    task automatic start(input logic run_val);
        rst = 1'b1;
        clr = 1'b1;
        run = run_val;
        step(2);
        rst = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        clr = 1'b1;
        clear_rom();
        step(2);
        check_eq("rst_pc",       pc,       0);
        check_eq("rst_sel_a",    sel_a,    0);
        check_eq("rst_sel_b",    sel_b,    0);
        check_eq("rst_sel_w",    sel_w,    0);
        check_eq("rst_write_en", write_en, 0);
        check_eq("rst_data_in",  data_in,  0);
        check_eq("rst_zero",     zero,     0);
        check_eq("rst_halted",   halted,   0);
        check_eq("rst_illegal",  illegal,  0);

        // LDI r0,5; LDI r1,3; ADD r0,r1; HALT
        clear_rom();
        rom[0] = 12'h105; rom[1] = 12'h143; rom[2] = 12'h310; rom[3] = 12'hA00;
        start(1'b1);
        step(4);
        check_eq("p1_we_c4",   write_en, 1);
        check_eq("p1_din_c4",  data_in,  5);
        check_eq("p1_selw_c4", sel_w,    0);
        step(1);
        check_eq("p1_we_c5",   write_en, 0);
        check_eq("p1_pc_c5",   pc,       1);
        step(3);
        check_eq("p1_we_c8",   write_en, 1);
        check_eq("p1_din_c8",  data_in,  3);
        check_eq("p1_selw_c8", sel_w,    1);
        step(4);
        check_eq("p1_we_c12",  write_en, 1);
        check_eq("p1_din_c12", data_in,  8);
        check_eq("p1_zero_c12", zero,    0);
        step(3);
        check_eq("p1_halt_c15", halted,  0);
        step(1);
        check_eq("p1_halt_c16", halted,  1);
        check_eq("p1_pc_c16",   pc,      3);
        check_eq("p1_r0",       regs[0], 8);
        check_eq("p1_writes",   wr_count, 3);
        step(4);
        check_eq("p1_pc_frozen", pc,     3);

        // LDI r2,7; SUB r2,r2; JZ 6 (taken) -> LDI r3,A; HALT
        clear_rom();
        rom[0] = 12'h187; rom[1] = 12'h4A0; rom[2] = 12'h906; rom[3] = 12'hA00;
        rom[6] = 12'h1CA; rom[7] = 12'hA00;
        start(1'b1);
        step(8);
        check_eq("jz_zero_c8",  zero,    1);
        check_eq("jz_din_c8",   data_in, 0);
        step(5);
        check_eq("jz_pc_c13",   pc,      6);
        step(7);
        check_eq("jz_halt_c20", halted,  1);
        check_eq("jz_pc_c20",   pc,      7);
        check_eq("jz_r3",       regs[3], 4'hA);

        // LDI r2,7; SUB r2,r1 (nonzero); JZ 6 not taken -> HALT at 3
        clear_rom();
        rom[0] = 12'h187; rom[1] = 12'h490; rom[2] = 12'h906; rom[3] = 12'hA00;
        rom[6] = 12'h1CA;
        start(1'b1);
        step(8);
        check_eq("nz_zero_c8",  zero,    0);
        step(5);
        check_eq("nz_pc_c13",   pc,      3);
        step(3);
        check_eq("nz_halt_c16", halted,  1);
        check_eq("nz_r2",       regs[2], 7);

        // LDI r0,F; LDI r1,1; ADD r0,r1 -> wraps to 0
        clear_rom();
        rom[0] = 12'h10F; rom[1] = 12'h141; rom[2] = 12'h310; rom[3] = 12'hA00;
        start(1'b1);
        step(12);
        check_eq("ovf_we_c12",   write_en, 1);
        check_eq("ovf_din_c12",  data_in,  0);
        check_eq("ovf_zero_c12", zero,     1);

        // All NOPs: pc steps through 15 and wraps to 0
        clear_rom();
        start(1'b1);
        step(64);
        check_eq("wrap_pc_c64",  pc,       15);
        step(1);
        check_eq("wrap_pc_c65",  pc,       0);
        check_eq("wrap_writes",  wr_count, 0);

        // Reset during EXEC of ADD r0,r0
        clear_rom();
        rom[0] = 12'h105; rom[1] = 12'h300;
        start(1'b1);
        step(7);
        rst = 1'b1;
        step(1);
        check_eq("abort_we",     write_en, 0);
        check_eq("abort_pc",     pc,       0);
        check_eq("abort_sel_a",  sel_a,    0);
        check_eq("abort_sel_w",  sel_w,    0);
        check_eq("abort_din",    data_in,  0);
        check_eq("abort_halted", halted,   0);
        rst = 1'b0;
        run = 1'b0;
        step(1);
        check_eq("abort_writes", wr_count, 1);
        check_eq("abort_r0",     regs[0],  5);
        check_eq("abort_idle_pc", pc,      0);

        // Drop run during DECODE of LDI r1,9; resume with LDI r2,4
        clear_rom();
        rom[0] = 12'h149; rom[1] = 12'h184; rom[2] = 12'hA00;
        start(1'b1);
        step(2);
        run = 1'b0;
        step(2);
        check_eq("run_we_c4",   write_en, 1);
        check_eq("run_din_c4",  data_in,  9);
        check_eq("run_selw_c4", sel_w,    1);
        step(4);
        check_eq("run_pc_c8",   pc,       1);
        check_eq("run_writes",  wr_count, 1);
        check_eq("run_r1",      regs[1],  9);
        run = 1'b1;
        step(4);
        check_eq("run_we_c12",  write_en, 1);
        check_eq("run_din_c12", data_in,  4);
        check_eq("run_selw_c12", sel_w,   2);
        step(1);
        check_eq("run_pc_c13",  pc,       2);

        // Undefined opcode 0xC
        clear_rom();
        rom[0] = 12'hC00; rom[1] = 12'hA00;
        start(1'b1);
        step(4);
`ifdef ILLEGAL_TRAP_EN
        check_eq("ill_illegal", illegal,  1);
        check_eq("ill_halted",  halted,   1);
        check_eq("ill_pc",      pc,       0);
        step(4);
        check_eq("ill_hold",    illegal,  1);
        check_eq("ill_writes",  wr_count, 0);
`else
        check_eq("ill_illegal", illegal,  0);
        check_eq("ill_we",      write_en, 0);
        step(1);
        check_eq("ill_pc",      pc,       1);
        step(3);
        check_eq("ill_halted",  halted,   1);
        check_eq("ill_writes",  wr_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
